// File: rtl/ddr2_init_checker.sv
// ddr2_init_checker
// Watches the DDR2 command bus during power-up and follows the JEDEC init
// order: PALL, EMR2, EMR3, EMR1 (DLL on), MR (DLL reset), PALL, AREF x2,
// MR, EMR1 (OCD default), EMR1 (OCD exit). It also checks the minimum
// spacing between commands, records the values loaded into the mode
// registers, and reports either completion or the first error it sees.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   cke        sampled CKE
//   ba         sampled bank address (BA_BITS)
//   cmd        {cs_n, ras_n, cas_n, we_n}
//   addr       sampled address (ADDR_BITS)
//   init_done  full sequence seen with no error
//   init_err   sticky error flag
//   err_code   cause of the first error
//   step       current sequence state index
//   mr_reg / emr1_reg / emr2_reg / emr3_reg  last value loaded into each register
//   cas_lat    mr_reg[6:4]
//   burst_len  mr_reg[2:0]
//   add_lat    emr1_reg[5:3]
module ddr2_init_checker #(
    parameter int BA_BITS   = 3,
    parameter int ADDR_BITS = 13,
    parameter int T_CKE_PRE = 80,
    parameter int T_RP_CK   = 4,
    parameter int T_MRD_CK  = 2,
    parameter int T_RFC_CK  = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cke,
    input  logic [BA_BITS-1:0]   ba,
    input  logic [3:0]           cmd,
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 init_done,
    output logic                 init_err,
    output logic [3:0]           err_code,
    output logic [3:0]           step,
    output logic [ADDR_BITS-1:0] mr_reg,
    output logic [ADDR_BITS-1:0] emr1_reg,
    output logic [ADDR_BITS-1:0] emr2_reg,
    output logic [ADDR_BITS-1:0] emr3_reg,
    output logic [2:0]           cas_lat,
    output logic [2:0]           burst_len,
    output logic [2:0]           add_lat
);

    typedef enum logic [3:0] {
        S_WAIT_CKE  = 4'd0,
        S_EMR2      = 4'd1,
        S_EMR3      = 4'd2,
        S_EMR1_DLL  = 4'd3,
        S_MR_DLLRST = 4'd4,
        S_PRE_ALL   = 4'd5,
        S_AREF1     = 4'd6,
        S_AREF2     = 4'd7,
        S_MR_RUN    = 4'd8,
        S_OCD_DFLT  = 4'd9,
        S_OCD_EXIT  = 4'd10,
        S_DONE      = 4'd11,
        S_ERR       = 4'd15
    } state_t;

    // Type of the most recent command, used to pick which spacing rule
    // applies to the next one. Commands that carry no spacing rule map to NONE.
    typedef enum logic [1:0] {
        L_NONE = 2'd0,
        L_PRE  = 2'd1,
        L_LM   = 2'd2,
        L_AREF = 2'd3
    } last_t;

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_LM   = 4'b0000;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [15:0] CKE_MIN  = 16'(T_CKE_PRE);
    localparam logic [15:0] RP_MIN   = 16'(T_RP_CK);
    localparam logic [15:0] MRD_MIN  = 16'(T_MRD_CK);
    localparam logic [15:0] RFC_MIN  = 16'(T_RFC_CK);

    state_t      state, state_next;
    last_t       last_type;
    logic [15:0] cke_cnt;
    logic [15:0] gap_cnt;
    logic [3:0]  err_code_next;
    logic [3:0]  cause;
    logic        type_ok, bank_ok, addr_ok;

    // With cs_n high the device is deselected, so the other three bits are
    // ignored and the cycle counts as a NOP.
    logic is_cmd, is_pre, is_lm, is_aref;
    assign is_cmd  = !cmd[3] && (cmd != CMD_NOP);
    assign is_pre  = (cmd == CMD_PRE);
    assign is_lm   = (cmd == CMD_LM);
    assign is_aref = (cmd == CMD_AREF);

    // Register state, counters, and mode-register captures.
    // gap_cnt is loaded with 1 on a command edge, so when the next command
    // arrives it holds the edge distance k. After reset it saturates without
    // causing errors, because last_type stays NONE until the first command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT_CKE;
            err_code  <= 4'd0;
            last_type <= L_NONE;
            cke_cnt   <= 16'd0;
            gap_cnt   <= 16'd0;
            mr_reg    <= '0;
            emr1_reg  <= '0;
            emr2_reg  <= '0;
            emr3_reg  <= '0;
        end else begin
            state    <= state_next;
            err_code <= err_code_next;
            if (!cke)
                cke_cnt <= 16'd0;
            else if (cke_cnt != 16'hFFFF)
                cke_cnt <= cke_cnt + 16'd1;
            if (is_cmd) begin
                gap_cnt <= 16'd1;
                if (is_pre)
                    last_type <= L_PRE;
                else if (is_lm)
                    last_type <= L_LM;
                else if (is_aref)
                    last_type <= L_AREF;
                else
                    last_type <= L_NONE;
            end else if (gap_cnt != 16'hFFFF) begin
                gap_cnt <= gap_cnt + 16'd1;
            end
            // An LM is still captured in the cycle it raises an error. Once
            // the checker is in the error state it ignores the bus.
            if (is_lm && state != S_ERR) begin
                case (ba)
                    BA_BITS'(0): mr_reg   <= addr;
                    BA_BITS'(1): emr1_reg <= addr;
                    BA_BITS'(2): emr2_reg <= addr;
                    BA_BITS'(3): emr3_reg <= addr;
                    default: ;
                endcase
            end
        end
    end

    // Work out, for each state, which command, bank and address field it expects.
    always_comb begin
        type_ok = 1'b1;
        bank_ok = 1'b1;
        addr_ok = 1'b1;
        case (state)
            S_WAIT_CKE, S_PRE_ALL: begin
                type_ok = is_pre;
                addr_ok = addr[10];
            end
            S_EMR2: begin
                type_ok = is_lm;
                bank_ok = (ba == BA_BITS'(2));
            end
            S_EMR3: begin
                type_ok = is_lm;
                bank_ok = (ba == BA_BITS'(3));
            end
            S_EMR1_DLL: begin
                type_ok = is_lm;
                bank_ok = (ba == BA_BITS'(1));
                addr_ok = !addr[0];
            end
            S_MR_DLLRST: begin
                type_ok = is_lm;
                bank_ok = (ba == BA_BITS'(0));
                addr_ok = addr[8];
            end
            S_AREF1, S_AREF2: type_ok = is_aref;
            S_MR_RUN: begin
                type_ok = is_lm;
                bank_ok = (ba == BA_BITS'(0));
                addr_ok = !addr[8];
            end
            S_OCD_DFLT: begin
                type_ok = is_lm;
                bank_ok = (ba == BA_BITS'(1));
                addr_ok = (addr[9:7] == 3'b111);
            end
            S_OCD_EXIT: begin
                type_ok = is_lm;
                bank_ok = (ba == BA_BITS'(1));
                addr_ok = (addr[9:7] == 3'b000);
            end
            default: ;
        endcase
    end

    // Pick the highest-priority error cause, then choose the next state.
    // Once the sequence is DONE, order checks stop, but CKE and spacing
    // checks keep running.
    always_comb begin
        state_next    = state;
        err_code_next = err_code;
        cause         = 4'd0;
        if (state != S_ERR) begin
            if (!cke && (is_cmd || state != S_WAIT_CKE))
                cause = 4'd7;
            else if (state == S_WAIT_CKE && is_pre && cke_cnt < CKE_MIN)
                cause = 4'd8;
            else if (is_cmd && last_type == L_PRE && gap_cnt < RP_MIN)
                cause = 4'd4;
            else if (is_cmd && last_type == L_LM && gap_cnt < MRD_MIN)
                cause = 4'd5;
            else if (is_cmd && last_type == L_AREF && gap_cnt < RFC_MIN)
                cause = 4'd6;
            else if (is_cmd && state != S_DONE) begin
                if (!type_ok)
                    cause = 4'd1;
                else if (!bank_ok)
                    cause = 4'd2;
                else if (!addr_ok)
                    cause = 4'd3;
            end

            if (cause != 4'd0) begin
                state_next    = S_ERR;
                err_code_next = cause;
            end else if (is_cmd && state != S_DONE) begin
                state_next = state_t'(state + 4'd1);
            end
        end
    end

    assign init_done = (state == S_DONE);
    assign init_err  = (state == S_ERR);
    assign step      = state;
    assign cas_lat   = mr_reg[6:4];
    assign burst_len = mr_reg[2:0];
    assign add_lat   = emr1_reg[5:3];

endmodule

// File: tb/tb_ddr2_init_checker.sv
// Directed bench for ddr2_init_checker. The expected values were worked out
// by hand from the DDR2 init order and the command spacing rules.
module tb_ddr2_init_checker;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] LM   = 4'b0000;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] ACT  = 4'b0011;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke;
    logic [2:0]  ba;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        init_done, init_err;
    logic [3:0]  err_code, step;
    logic [12:0] mr_reg, emr1_reg, emr2_reg, emr3_reg;
    logic [2:0]  cas_lat, burst_len, add_lat;

    int testsRun = 0;
    int testsFailed = 0;

    // Nominal init sequence: command, bank, address, and the edge distance
    // from the previous command (entry 0: number of cke-high cycles first).
    logic [3:0]  seqCmd  [11] = '{PRE, LM, LM, LM, LM, PRE, AREF, AREF, LM, LM, LM};
    logic [2:0]  seqBa   [11] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    logic [12:0] seqAddr [11] = '{13'h400, 13'h000, 13'h000, 13'h000, 13'hB62, 13'h400,
                                  13'h000, 13'h000, 13'h432, 13'h380, 13'h010};
    int          seqGap  [11] = '{100, 4, 2, 2, 2, 2, 4, 26, 26, 2, 2};

    ddr2_init_checker dut (
        .clk(clk), .rst(rst), .cke(cke), .ba(ba), .cmd(cmd), .addr(addr),
        .init_done(init_done), .init_err(init_err), .err_code(err_code), .step(step),
        .mr_reg(mr_reg), .emr1_reg(emr1_reg), .emr2_reg(emr2_reg), .emr3_reg(emr3_reg),
        .cas_lat(cas_lat), .burst_len(burst_len), .add_lat(add_lat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one command for a single edge, then return the bus to NOP.
    task automatic applyStimulus(input logic [3:0] c, input logic [2:0] b, input logic [12:0] a);
        cmd = c;
        ba = b;
        addr = a;
        @(posedge clk);
        #1;
        cmd = NOP;
        ba = 3'd0;
        addr = 13'd0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        cke = 1'b0;
        cmd = NOP;
        ba = 3'd0;
        addr = 13'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Play entries first..last of the nominal sequence. secondArefGap
    // replaces the spacing in front of the second AREF.
    task automatic playSeq(input int first, input int last, input int secondArefGap);
        cke = 1'b1;
        for (int i = first; i <= last; i++) begin
            int g;
            g = (i == 7) ? secondArefGap : seqGap[i];
            idle((i == 0) ? g : g - 1);
            applyStimulus(seqCmd[i], seqBa[i], seqAddr[i]);
        end
    endtask

    initial begin
        doReset();
        checkOutput("reset_step", 32'(step), 32'd0);
        checkOutput("reset_done", 32'(init_done), 32'd0);
        checkOutput("reset_err", 32'(init_err), 32'd0);

        // Nominal sequence
        playSeq(0, 9, 26);
        checkOutput("nom_step10", 32'(step), 32'd10);
        checkOutput("nom_not_done", 32'(init_done), 32'd0);
        playSeq(10, 10, 26);
        checkOutput("nom_done", 32'(init_done), 32'd1);
        checkOutput("nom_step", 32'(step), 32'd11);
        checkOutput("nom_mr", 32'(mr_reg), 32'h432);
        checkOutput("nom_emr1", 32'(emr1_reg), 32'h010);
        checkOutput("nom_cas", 32'(cas_lat), 32'd3);
        checkOutput("nom_bl", 32'(burst_len), 32'd2);
        checkOutput("nom_al", 32'(add_lat), 32'd2);
        checkOutput("nom_err", 32'(init_err), 32'd0);
        idle(3);
        applyStimulus(ACT, 3'd0, 13'd0);
        checkOutput("done_other_ok", 32'(step), 32'd11);

        // Second AREF too early -> TRFC
        doReset();
        playSeq(0, 7, 25);
        checkOutput("trfc_err", 32'(init_err), 32'd1);
        checkOutput("trfc_code", 32'(err_code), 32'd6);
        checkOutput("trfc_step", 32'(step), 32'd15);
        checkOutput("trfc_done", 32'(init_done), 32'd0);
        idle(30);
        applyStimulus(LM, 3'd0, 13'h432);
        checkOutput("trfc_ignored_step", 32'(step), 32'd15);
        checkOutput("trfc_ignored_mr", 32'(mr_reg), 32'hB62);

        // CKE only 79 cycles before the first PRE, then exactly 80
        doReset();
        cke = 1'b1;
        idle(79);
        applyStimulus(PRE, 3'd0, 13'h400);
        checkOutput("early79_code", 32'(err_code), 32'd8);
        doReset();
        cke = 1'b1;
        idle(80);
        applyStimulus(PRE, 3'd0, 13'h400);
        checkOutput("early80_step", 32'(step), 32'd1);
        checkOutput("early80_err", 32'(init_err), 32'd0);

        // Wrong bank at step 1; the LM is still captured
        idle(3);
        applyStimulus(LM, 3'd3, 13'h055);
        checkOutput("bank_code", 32'(err_code), 32'd2);
        checkOutput("bank_capture", 32'(emr3_reg), 32'h055);

        // ACT at step 0 -> illegal command
        doReset();
        cke = 1'b1;
        idle(100);
        applyStimulus(ACT, 3'd0, 13'd0);
        checkOutput("illegal_code", 32'(err_code), 32'd1);

        // Step 4: LM with wrong bank, back-to-back -> TMRD outranks BAD_BANK
        doReset();
        playSeq(0, 3, 26);
        checkOutput("simul_step4", 32'(step), 32'd4);
        applyStimulus(LM, 3'd1, 13'h001);
        checkOutput("simul_code", 32'(err_code), 32'd5);
        checkOutput("simul_capture", 32'(emr1_reg), 32'h001);

        // Reset in the middle of the sequence, then a full run, then CKE drop
        doReset();
        playSeq(0, 6, 26);
        checkOutput("mid_step7", 32'(step), 32'd7);
        doReset();
        checkOutput("mid_rst_step", 32'(step), 32'd0);
        checkOutput("mid_rst_mr", 32'(mr_reg), 32'd0);
        checkOutput("mid_rst_done", 32'(init_done), 32'd0);
        checkOutput("mid_rst_code", 32'(err_code), 32'd0);
        playSeq(0, 10, 26);
        checkOutput("mid_done", 32'(init_done), 32'd1);
        idle(5);
        cke = 1'b0;
        idle(1);
        checkOutput("ckelow_code", 32'(err_code), 32'd7);
        checkOutput("ckelow_done", 32'(init_done), 32'd0);
        checkOutput("ckelow_err", 32'(init_err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ddr2_init_checker.md
Name: ddr2_init_checker

Overview:
- Memory-side responder for the DDR2 power-up sequence. Samples the controller's CKE/BA/command/address bus and tracks the JEDEC init order.
- Checks minimum command spacing, captures MR/EMR1/EMR2/EMR3, and reports completion or a sticky error.
- Sits on the DDR2 command bus in simulation benches and on-chip debug builds, alongside the init sequencer it checks.

Parameters:
- BA_BITS, 3, bank address width.
- ADDR_BITS, 13, row/mode address width; must be ≥ 11.
- T_CKE_PRE, 80, minimum cycles CKE high before the first PRE (400 ns at tCK = 5 ns).
- T_RP_CK, 4, minimum cycles from a PRE to the next command.
- T_MRD_CK, 2, minimum cycles from an LM to the next command.
- T_RFC_CK, 26, minimum cycles from an AREF to the next command.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cke  in  1  sampled CKE.
- ba  in  BA_BITS  sampled bank address.
- cmd  in  4  {cs_n,ras_n,cas_n,we_n}.
- addr  in  ADDR_BITS  sampled address.
- init_done  out  1  full sequence observed without error.
- init_err  out  1  sticky error flag.
- err_code  out  4  first error cause.
- step  out  4  current sequence state index.
- mr_reg / emr1_reg / emr2_reg / emr3_reg  out  ADDR_BITS each  last value loaded into each mode register.
- cas_lat  out  3  mr_reg[6:4].
- burst_len  out  3  mr_reg[2:0].
- add_lat  out  3  emr1_reg[5:3].

Behaviour:
- Reset: all outputs 0, step = 0 (WAIT_CKE), counters cleared.
- Latency: inputs sampled each rising edge; the resulting output update is visible the next cycle.
- Decode:
  - NOP = 0111; cs_n = 1 is deselect, treated as NOP.
  - PRE = 0010; LM = 0000; AREF = 0001.
  - Any other code is "other".
  - A "command" is any non-NOP.
- Counters:
  - cke_cnt counts cycles with cke = 1 and clears when cke = 0.
  - gap_cnt gives the distance, in cycles, from the last command edge. It saturates and holds saturated until the first command.
- Sequence FSM (step value: state, expected command):
  - 0 WAIT_CKE: PRE with addr[10] = 1 (precharge-all); cke_cnt ≥ T_CKE_PRE.
  - 1: LM, ba = 2 (EMR2).
  - 2: LM, ba = 3 (EMR3).
  - 3: LM, ba = 1, addr[0] = 0 (DLL enable).
  - 4: LM, ba = 0, addr[8] = 1 (DLL reset).
  - 5: PRE, addr[10] = 1.
  - 6: AREF.
  - 7: AREF.
  - 8: LM, ba = 0, addr[8] = 0.
  - 9: LM, ba = 1, addr[9:7] = 111 (OCD default).
  - 10: LM, ba = 1, addr[9:7] = 000 (OCD exit), then go to 11.
  - 11 DONE: init_done = 1. Any PRE/LM/AREF/other is accepted; LM still updates the register for its ba; timing checks continue.
  - 15 ERR: terminal until rst.
- Advancing: the expected command with all field checks passing advances step by 1. NOPs never advance and never error.
- Register capture: every LM with ba ≤ 3 writes addr into MR (0), EMR1 (1), EMR2 (2) or EMR3 (3). Capture occurs even in the cycle it causes an error. ba > 3 is not captured.
- Errors: only the first is recorded. init_err = 1, step = 15, init_done stays 0. Priority when several apply in one cycle, highest first:
  - 7 CKE_LOW: command with cke = 0, or cke falls after step 0.
  - 8 CKE_EARLY: first PRE with cke_cnt < T_CKE_PRE.
  - 4 TRP: gap from PRE < T_RP_CK.
  - 5 TMRD: gap from LM < T_MRD_CK.
  - 6 TRFC: gap from AREF < T_RFC_CK.
  - 1 ILLEGAL_CMD: wrong command type for the state.
  - 2 BAD_BANK: wrong ba for the state.
  - 3 BAD_ADDR: field check failed.
- Gap rule: a command at edge N after a command at edge N−k is legal iff k ≥ T for the previous command's type. Back-to-back commands give k = 1.
- After DONE: timing and CKE errors still set init_err and err_code, and drop init_done to 0.
- Reset mid-sequence: everything returns to reset values on the next edge; the sequence restarts at step 0.
- Sizing: gap_cnt and cke_cnt are 16 bits, saturating at 65535. Parameters must be < 65535.

Test Plan:
- Nominal: cke high for 100 cycles, then the 11-command sequence with gaps 4, 2, 2, 2, 2, 4, 26, 26, 2, 2, using LM4 addr 0x0B62, LM5 0x0432, LM6 0x0380, LM7 0x0010. Required: init_done = 1 one cycle after LM7; step = 11; mr_reg = 0x0432, emr1_reg = 0x0010; cas_lat = 3, burst_len = 2, add_lat = 2; init_err = 0.
- Timing violation: nominal sequence but second AREF 25 cycles after the first. Required: init_err = 1, err_code = 6, step = 15, init_done = 0; later commands ignored.
- Early start: first PRE after cke has been high 79 cycles. Required: err_code = 8. Repeat at exactly 80 cycles: step advances to 1.
- Order error: LM with ba = 3 issued at step 1. Required: err_code = 2. Then ACT (0011) issued from a fresh reset at step 0. Required: err_code = 1.
- Simultaneous faults: at step 4, LM with ba = 1 one cycle after the previous LM. Required: err_code = 5, since timing outranks bank.
- Reset mid-sequence: assert rst at step 7. Required: all outputs 0 next cycle; the nominal sequence then completes normally. After DONE, cke drop gives err_code = 7 and init_done = 0.
